// File: rtl/booth_mul_if.sv
// ---------------------------------------------------------------------------
// booth_mul_if
//   This bundle groups the handshake and data buses that connect a
//   booth_mul multiplier to the block that uses it.
//
//   Signals:
//     bgn          master -> slave   start request
//     ibusA        master -> slave   multiplicand M (signed, WIDTH bits)
//     ibusB        master -> slave   multiplier Q (signed, WIDTH bits)
//     obusA        slave  -> master  product high half; 'z unless fin=1
//     obusB        slave  -> master  product low half;  'z unless fin=1
//     busy         slave  -> master  operation in progress
//     fin          slave  -> master  one-cycle done pulse
//
//   Modports:
//     master       used by the requester
//     slave        used by the multiplier
// ---------------------------------------------------------------------------
interface booth_mul_if #(
    parameter int WIDTH = 32
);
    logic             bgn;
    logic [WIDTH-1:0] ibusA;
    logic [WIDTH-1:0] ibusB;
    logic [WIDTH-1:0] obusA;
    logic [WIDTH-1:0] obusB;
    logic             busy;
    logic             fin;

    modport master (
        output bgn, ibusA, ibusB,
        input  obusA, obusB, busy, fin
    );

    modport slave (
        input  bgn, ibusA, ibusB,
        output obusA, obusB, busy, fin
    );
endinterface

// File: rtl/booth_mul.sv
// ---------------------------------------------------------------------------
// booth_mul
//   This block is a sequential signed radix-4 Booth multiplier. It retires
//   two multiplier bits per cycle and produces the full 2*WIDTH-bit product.
//   A result takes WIDTH/2 iteration cycles plus one DONE cycle.
//
//   Ports:
//     clk   in    single clock, rising edge
//     rst   in    synchronous, active-high reset
//     bus   slave booth_mul_if:
//           bgn      start request, sampled only in IDLE
//           ibusA    multiplicand, captured when bgn is accepted
//           ibusB    multiplier, captured when bgn is accepted
//           obusA    product[2*WIDTH-1:WIDTH]; driven only while fin=1
//           obusB    product[WIDTH-1:0]; driven only while fin=1
//           busy     high from the cycle after acceptance to the end of fin
//           fin      one-cycle done pulse
//
//   Optional feature:
//     MUL_ZERO_SKIP_EN
//           When this macro is defined, a zero operand skips the iterations.
//           The block then goes straight to DONE with a product of 0.
// ---------------------------------------------------------------------------
module booth_mul #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    booth_mul_if.slave  bus
);
    localparam int             W2  = WIDTH + 2;
    localparam int             CW  = $clog2(WIDTH / 2) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [W2-1:0]    a_q, a_d;        // accumulator, signed
    logic [WIDTH:0]   q_q, q_d;        // {multiplier, q_-1}
    logic [W2-1:0]    m_q, m_d;        // sign-extended multiplicand
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fin_q, fin_d;
    logic             busy_q, busy_d;

    logic [W2-1:0]       addend;
    logic [W2-1:0]       a_sum;
    logic [W2+WIDTH:0]   shifted;
    logic                zero_skip;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_skip = (bus.ibusA == '0) || (bus.ibusB == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Radix-4 recoding of the current bit triplet.
    always_comb begin
        addend = '0;
        unique case (q_q[2:0])
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m_q << 1;
            3'b100:         addend = -(m_q << 1);
            3'b101, 3'b110: addend = -m_q;
            default:        addend = '0;
        endcase
    end

    // The two guard bits of A keep +/-2M and the most-negative squared case
    // in range, so this sum never overflows.
    assign a_sum   = a_q + addend;
    assign shifted = $signed({a_sum, q_q}) >>> 2;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.bgn) begin
                    a_d     = '0;
                    q_d     = zero_skip ? '0 : {bus.ibusB, 1'b0};
                    m_d     = {{2{bus.ibusA[WIDTH-1]}}, bus.ibusA};
                    cnt_d   = '0;
                    state_d = zero_skip ? DONE : ITER;
                end
            end
            ITER: begin
                {a_d, q_d} = shifted;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The status outputs are registered versions of the state being entered.
        fin_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.fin   = fin_q;
    assign bus.busy  = busy_q;
    assign bus.obusA = fin_q ? a_q[WIDTH-1:0] : {WIDTH{1'bz}};
    assign bus.obusB = fin_q ? q_q[WIDTH:1]   : {WIDTH{1'bz}};
endmodule

// File: tb/tb_booth_mul.sv
module tb_booth_mul;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH / 2 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    booth_mul_if #(.WIDTH(WIDTH)) bus ();

    booth_mul #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 1;
`endif
        return LAT;
    endfunction

    // Called at #1 after an edge with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] prod;
        bus.bgn   = 1'b1;
        bus.ibusA = a;
        bus.ibusB = b;
        @(posedge clk); #1;
        bus.bgn   = 1'b0;
        bus.ibusA = $urandom;
        bus.ibusB = $urandom;
        n = 1;
        check({tag, "_busy"}, 64'(bus.busy), 64'(1));
        while (!bus.fin && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        prod = {bus.obusA, bus.obusB};
        check({tag, "_lat"}, 64'(n), 64'(ref_lat(a, b)));
        check({tag, "_prod"}, prod, ref_mul(a, b));
        $display("op %s: %h * %h -> %h lat=%0d", tag, a, b, prod, n);
        @(posedge clk); #1;
        check({tag, "_fin_drop"}, 64'({bus.fin, bus.busy}), 64'(0));
    endtask

    initial begin
        int fins;
        int fin_at[$];
        logic [31:0] a, b;
        bus.bgn = 1'b0; bus.ibusA = '0; bus.ibusB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fin", 64'(bus.fin), 64'(0));
        check("reset_busy", 64'(bus.busy), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("3x5",  32'd3, 32'd5);
        run_op("m7x6", 32'hFFFFFFF9, 32'd6);
        run_op("minxmin", 32'h80000000, 32'h80000000);
        run_op("maxxmin", 32'h7FFFFFFF, 32'h80000000);
        run_op("0x1234", 32'd0, 32'h1234);
        run_op("m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 4) a = 32'($signed(16'($urandom)));
            run_op($sformatf("rnd%0d", i), a, b);
        end

        // bgn pulses during an operation must be ignored.
        bus.bgn = 1'b1; bus.ibusA = 32'd1234; bus.ibusB = 32'hFFFF0001;
        @(posedge clk); #1;
        bus.bgn = 1'b0;
        fins = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.fin) begin
                fins++;
                check("pulse_prod", {bus.obusA, bus.obusB}, ref_mul(32'd1234, 32'hFFFF0001));
            end
            bus.bgn = (i == 5 || i == 10);
            @(posedge clk); #1;
        end
        bus.bgn = 1'b0;
        check("pulse_fins", 64'(fins), 64'(1));
        $display("op pulse: fins=%0d", fins);

        // reset mid-operation kills the result.
        bus.bgn = 1'b1; bus.ibusA = 32'd77; bus.ibusB = 32'd99;
        @(posedge clk); #1;
        bus.bgn = 1'b0;
        fins = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.fin) fins++;
            rst = (i == 8);
            if (i == 9) check("rst_busy", 64'(bus.busy), 64'(0));
            @(posedge clk); #1;
        end
        rst = 1'b0;
        check("rst_fins", 64'(fins), 64'(0));
        $display("op reset: fins=%0d", fins);

        // held-high bgn restarts every time IDLE is reached.
        bus.bgn = 1'b1; bus.ibusA = 32'hFFFFFF00; bus.ibusB = 32'd300;
        @(posedge clk); #1;
        for (int i = 1; i <= 50; i++) begin
            if (bus.fin) fin_at.push_back(i);
            @(posedge clk); #1;
        end
        bus.bgn = 1'b0;
        check("held_nfins", 64'(fin_at.size()), 64'(2));
        if (fin_at.size() >= 2) begin
            check("held_first", 64'(fin_at[0]), 64'(LAT));
            check("held_gap", 64'(fin_at[1] - fin_at[0]), 64'(LAT + 1));
        end
        $display("op held: fins=%0d", fin_at.size());
        for (int i = 0; i < 40 && bus.busy; i++) begin
            @(posedge clk); #1;
        end
        check("held_idle", 64'(bus.busy), 64'(0));

        run_op("after", 32'd3, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
